muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned MULTU/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// One shift-add or restoring shift-subtract step per RUN cycle; the result lands in HI/LO on the last step.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_MD_START,
  input  logic [1:0]       IN_MD_OP,
  input  logic [WIDTH-1:0] IN_MD_A,
  input  logic [WIDTH-1:0] IN_MD_B,
  input  logic             IN_MD_FLUSH,
  input  logic             IN_MD_RDREQ,
  output logic [WIDTH-1:0] OUT_HI,
  output logic [WIDTH-1:0] OUT_LO,
  output logic             OUT_BUSY,
  output logic             OUT_DONE,
  output logic             OUT_STALL,
  output logic             OUT_MD_ZF
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             zf_q;

  logic             accept, start_iter, last_step;
  logic [WIDTH:0]   sum, shl;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] hi_nx, lo_nx;

  // One iteration: acc_hi is the running high half (product) or partial remainder (divide);
  // acc_lo shifts out multiplier bits or shifts in quotient bits.
  always_comb begin
    sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : '0);
    shl   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    ge    = (shl >= {1'b0, b_q});
    diff  = shl[WIDTH-1:0] - b_q;
    hi_nx = sum[WIDTH:1];
    lo_nx = {sum[0], acc_lo_q[WIDTH-1:1]};
    if (is_div_q) begin
      hi_nx = ge ? diff : shl[WIDTH-1:0];
      lo_nx = {acc_lo_q[WIDTH-2:0], ge};
    end
  end

  always_comb begin
    accept     = (state_q != RUN) && IN_MD_START && !IN_MD_FLUSH;
    start_iter = accept && !IN_MD_OP[1];
    last_step  = (cnt_q == LAST_CNT);
    state_d    = state_q;
    case (state_q)
      IDLE, DONE: state_d = start_iter ? RUN : IDLE;
      RUN: begin
        if (IN_MD_FLUSH)    state_d = IDLE;
        else if (last_step) state_d = DONE;
        else                state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      zf_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      if (start_iter)          cnt_q <= '0;
      else if (state_q == RUN) cnt_q <= cnt_q + 1'b1;
      if (accept && IN_MD_OP == OP_MTHI) hi_q <= IN_MD_A;
      if (accept && IN_MD_OP == OP_MTLO) lo_q <= IN_MD_A;
      // A flush on the completing edge discards the result.
      if (state_q == RUN && last_step && !IN_MD_FLUSH) begin
        hi_q <= hi_nx;
        lo_q <= lo_nx;
        zf_q <= ({hi_nx, lo_nx} == '0);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (start_iter) begin
      is_div_q <= IN_MD_OP[0];
      a_q      <= IN_MD_A;
      b_q      <= IN_MD_B;
      acc_hi_q <= '0;
      acc_lo_q <= IN_MD_OP[0] ? IN_MD_A : IN_MD_B;
    end else if (state_q == RUN) begin
      acc_hi_q <= hi_nx;
      acc_lo_q <= lo_nx;
    end
  end

  assign OUT_HI    = hi_q;
  assign OUT_LO    = lo_q;
  assign OUT_MD_ZF = zf_q;
  assign OUT_BUSY  = (state_q == RUN);
  assign OUT_DONE  = (state_q == DONE);
  assign OUT_STALL = IN_MD_RDREQ & OUT_BUSY;

endmodule
